// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: samples the converter word at a fixed rate into a FIFO and
// sends each sample as a framed 8N1 UART packet. Macro TELEM_CHECKSUM_EN adds an XOR checksum byte.
module telemetry_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SAMPLE_DIV   = 100000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    sample_in,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [SW-1:0] SMAX = SW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
`ifdef TELEM_CHECKSUM_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [SW-1:0] tick_q, tick_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [1:0]    st_q, st_d;
  logic [BW-1:0] clk_q, clk_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    pay_q, pay_d;
  logic [7:0]    seq_q, seq_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          push, pop, full, empty, push_ok;
  logic [7:0]    cur_byte;

  // Sample tick: count while enabled, capture on the terminal count
  always_comb begin
    tick_d = '0;
    push   = 1'b0;
    if (enable) begin
      if (tick_q == SMAX) push = 1'b1;
      else tick_d = tick_q + 1'b1;
    end
  end

  // FIFO bookkeeping; a pop frees the slot so a push into a full FIFO still lands
  always_comb begin
    full    = (lvl_q == FULL);
    empty   = (lvl_q == '0);
    pop     = (st_q == S_IDLE) && !empty;
    push_ok = push && (!full || pop);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    lvl_d   = lvl_q;
    if (push_ok && !pop) lvl_d = lvl_q + 1'b1;
    else if (!push_ok && pop) lvl_d = lvl_q - 1'b1;
    ovf_d   = ovf_q | (push & ~push_ok);
  end

  // Sample storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= sample_in;
  end

  // Packet FSM: start bit, 8 data bits, stop bit per byte, bytes back-to-back
  always_comb begin
    st_d   = st_q;
    clk_d  = clk_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    pay_d  = pay_q;
    seq_d  = seq_q;
    case (st_q)
      S_IDLE: begin
        if (pop) begin
          pay_d  = mem_q[rd_q];
          byte_d = '0;
          clk_d  = '0;
          st_d   = S_START;
        end
      end
      S_START: begin
        if (clk_q == BMAX) begin
          clk_d = '0;
          bit_d = '0;
          st_d  = S_DATA;
        end else clk_d = clk_q + 1'b1;
      end
      S_DATA: begin
        if (clk_q == BMAX) begin
          clk_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = S_STOP;
        end else clk_d = clk_q + 1'b1;
      end
      default: begin
        if (clk_q == BMAX) begin
          clk_d = '0;
          if (byte_q == LAST) begin
            st_d  = S_IDLE;
            seq_d = seq_q + 1'b1;
          end else begin
            byte_d = byte_q + 1'b1;
            st_d   = S_START;
          end
        end else clk_d = clk_q + 1'b1;
      end
    endcase
  end

  // Next line level from next state so uart_tx comes straight from a flop
  always_comb begin
    case (byte_d)
      2'd1: cur_byte = seq_q;
      2'd2: cur_byte = pay_d;
`ifdef TELEM_CHECKSUM_EN
      2'd3: cur_byte = 8'hA5 ^ seq_q ^ pay_d;
`endif
      default: cur_byte = 8'hA5;
    endcase
    case (st_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (st_d != S_IDLE);
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      st_q   <= S_IDLE;
      clk_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      pay_q  <= '0;
      seq_q  <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      st_q   <= st_d;
      clk_q  <= clk_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      pay_q  <= pay_d;
      seq_q  <= seq_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_level = lvl_q;
endmodule

// File: tb/tb_telemetry_uart_tx.sv
// tb_telemetry_uart_tx: table vectors, randomized packets against a byte-level
// model, overflow, full push+pop and reset-abort sequences.
module tb_telemetry_uart_tx;
  localparam int CPB = 4;
  localparam int SD  = 50;
  localparam int FD  = 4;
`ifdef TELEM_CHECKSUM_EN
  localparam int NB        = 4;
  localparam int FULL_EDGE = 300;
  localparam int OV_EDGE   = 350;
`else
  localparam int NB        = 3;
  localparam int FULL_EDGE = 350;
  localparam int OV_EDGE   = 400;
`endif
  localparam int PKT = NB * 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       uart_tx, busy, overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int seq_m  = 0;
  int run    = 0;
  logic [7:0] rx_q [$];
  logic [7:0] cap_q [$];

  typedef struct {
    logic [7:0] s;
    logic [7:0] seq;
    logic [7:0] cs;
  } vec_t;
  vec_t tv [4];

  telemetry_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_DIV(SD),
    .FIFO_DEPTH(FD)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_in(sample_in),
    .uart_tx(uart_tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Capture model: every SD-th consecutive enabled edge grabs sample_in
  always @(posedge clk) begin
    if (rst) run = 0;
    else if (enable) begin
      run++;
      if (run % SD == 0) cap_q.push_back(sample_in);
    end else run = 0;
  end

  // UART receiver: mid-bit sampling, LSB first, checks the stop bit
  initial begin : mon
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (!rst && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = uart_tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        chk("stop_bit", int'(uart_tx), 1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One capture from idle, with latency and packet-length checks
  task automatic send_one(input logic [7:0] s);
    int n;
    sample_in = s;
    enable = 1'b1;
    repeat (SD) @(posedge clk);
    #1 enable = 1'b0;
    chk("cap_level", int'(fifo_level), 1);
    chk("cap_tx", int'(uart_tx), 1);
    @(posedge clk); #1;
    chk("start_tx", int'(uart_tx), 0);
    chk("start_level", int'(fifo_level), 0);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", n, PKT);
    chk("gap_tx", int'(uart_tx), 1);
  endtask

  task automatic check_packets(input bit drops);
    logic [7:0] b0, b1, b2, b3, e;
    chk("rx_frag", rx_q.size() % NB, 0);
    while (rx_q.size() >= NB) begin
      b0 = rx_q.pop_front();
      b1 = rx_q.pop_front();
      b2 = rx_q.pop_front();
      chk("hdr", int'(b0), 'hA5);
      chk("seq", int'(b1), seq_m & 255);
      if (drops)
        while (cap_q.size() > 0 && cap_q[0] != b2) void'(cap_q.pop_front());
      e = (cap_q.size() > 0) ? cap_q.pop_front() : ~b2;
      chk("payload", int'(b2), int'(e));
`ifdef TELEM_CHECKSUM_EN
      b3 = rx_q.pop_front();
      chk("csum", int'(b3), int'(8'hA5 ^ 8'(seq_m) ^ e));
`else
      b3 = 8'h00;
`endif
      seq_m = (seq_m + 1) & 255;
    end
    if (!drops) chk("cap_left", cap_q.size(), 0);
    cap_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", int'(busy || fifo_level != 0), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_level", int'(fifo_level), 0);
    rst = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    rx_q.delete();
    cap_q.delete();
    seq_m = 0;
  endtask

  initial begin : main
    int n, rise, tgt, maxl;
    bit bprev;
    logic [7:0] b0, b1, b2, b3;

    tv[0] = '{8'h96, 8'h00, 8'h33};
    tv[1] = '{8'h2D, 8'h01, 8'h89};
    tv[2] = '{8'h00, 8'h02, 8'hA7};
    tv[3] = '{8'hFF, 8'h03, 8'h59};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("in_rst", int'({uart_tx, busy, overflow, fifo_level}), 'b1_0_0_000);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      chk("idle", int'({uart_tx, busy, overflow, fifo_level}), 'b1_0_0_000);
    end
    rx_q.delete();

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      send_one(tv[i].s);
      chk("tv_bytes", rx_q.size(), NB);
      if (rx_q.size() >= NB) begin
        b0 = rx_q.pop_front();
        b1 = rx_q.pop_front();
        b2 = rx_q.pop_front();
        chk("tv_hdr", int'(b0), 'hA5);
        chk("tv_seq", int'(b1), int'(tv[i].seq));
        chk("tv_pay", int'(b2), int'(tv[i].s));
`ifdef TELEM_CHECKSUM_EN
        b3 = rx_q.pop_front();
        chk("tv_csum", int'(b3), int'(tv[i].cs));
`endif
      end
      rx_q.delete();
      cap_q.delete();
      seq_m++;
    end

    // Random packets; seq wraps past 0xFF
    for (int i = 0; i < 254; i++) begin
      send_one(8'($urandom));
      check_packets(1'b0);
    end
    chk("seq_wrapped", seq_m, 2);

    // Overflow with enable held high
    enable = 1'b1;
    n = 0;
    maxl = 0;
    while (n < 600) begin
      @(posedge clk); #1;
      n++;
      sample_in = 8'($urandom);
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if (n == FULL_EDGE - 1) chk("ovf_lvl3", int'(fifo_level), 3);
      if (n == FULL_EDGE) chk("ovf_lvl4", int'(fifo_level), 4);
      if (n == OV_EDGE - 1) chk("ovf_pre", int'(overflow), 0);
      if (n == OV_EDGE) chk("ovf_set", int'(overflow), 1);
    end
    enable = 1'b0;
    chk("ovf_max", maxl, 4);
    drain();
    check_packets(1'b1);
    chk("ovf_sticky", int'(overflow), 1);

    // Capture coinciding with a pop from a full FIFO
    pulse_reset();
    enable = 1'b1;
    n = 0;
    rise = 0;
    bprev = 1'b0;
    while (fifo_level != 3'd4 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (busy && !bprev) rise = n;
      bprev = busy;
      sample_in = 8'($urandom);
    end
    enable = 1'b0;
    chk("pp_fill_edge", n, FULL_EDGE);
    tgt = rise + PKT + 1;
    while (n < tgt && n < 2000) begin
      @(posedge clk); #1;
      n++;
      sample_in = 8'($urandom);
      if (n == tgt - SD) enable = 1'b1;
      if (n == tgt - 1) begin
        chk("pp_pre_idle", int'(busy), 0);
        chk("pp_pre_lvl", int'(fifo_level), 4);
      end
    end
    enable = 1'b0;
    chk("pp_lvl", int'(fifo_level), 4);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_busy", int'(busy), 1);
    drain();
    check_packets(1'b0);
    chk("pp_ovf_end", int'(overflow), 0);

    // Reset during a 0 data bit of the header
    sample_in = 8'h3C;
    enable = 1'b1;
    repeat (SD) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    repeat (2 * CPB + 1) @(posedge clk);
    #1;
    chk("mid_tx0", int'(uart_tx), 0);
    chk("mid_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_tx", int'(uart_tx), 1);
    chk("async_busy", int'(busy), 0);
    pulse_reset();
    send_one(8'h5A);
    check_packets(1'b0);
    chk("post_rst_seq", seq_m, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
